// File: rtl/product_accumulator.sv
// product_accumulator
// Batch-sum stage behind the signed multiplier. Accepts COUNT signed
// products over a valid/ready handshake, adds them (sign-extended, wrapping)
// into an ACC_W-bit accumulator, then holds the finished sum with a sticky
// overflow flag until the consumer takes it. A synchronous clear aborts the
// current batch, and also discards a sum that is being held.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int COUNT  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_product,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    input  logic              out_ready,
    output logic              busy
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum_wrap;
    logic             add_ovf;
    logic             accept;

    // Sign-extend the product to accumulator width (no-op when widths match).
    if (ACC_W > PROD_W) begin : g_ext
        assign prod_ext = {{(ACC_W - PROD_W){in_product[PROD_W-1]}}, in_product};
    end else begin : g_noext
        assign prod_ext = in_product;
    end

    // Wrapping add; overflow when both addends agree in sign and the result does not.
    assign sum_wrap = acc_q + prod_ext;
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_wrap[ACC_W-1] != acc_q[ACC_W-1]);
    assign accept   = in_valid && (state_q == ST_ACCUM);

    // Next-state logic; clear overrides every other event in the cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_d = sum_wrap;
                        ovf_d = ovf_q | add_ovf;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Sum and flag stay frozen until the consumer takes them.
                    if (out_ready) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_ACCUM;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready     = (state_q == ST_ACCUM);
    assign out_valid    = (state_q == ST_HOLD);
    assign out_sum      = acc_q;
    assign out_overflow = ovf_q;
    assign busy         = (cnt_q != '0) || (state_q == ST_HOLD);

endmodule
